// File: rtl/packet_sink.sv
// NoC local-port receive endpoint: reassembles flits into packets, checks address/length,
// keeps saturating statistics. Optional payload sequence check under `PAYLOAD_CHECK_EN.
module packet_sink #(
   parameter int unsigned DATA_SIZE    = 8,
   parameter int unsigned ADDR_SIZE    = 4,
   parameter int unsigned ADDR         = 0,
   parameter int unsigned MAX_PACK_LEN = 16,
   parameter int unsigned READ_DELAY   = 0
) (
   input  logic                           clk,
   input  logic                           a_rst,
   input  logic [DATA_SIZE+ADDR_SIZE:0]   data_i,
   input  logic                           wr_ready_in,
   output logic                           r_ready_out,
   output logic [31:0]                    recv_packs,
   output logic [31:0]                    recv_flits,
   output logic [15:0]                    err_addr,
   output logic [15:0]                    err_len,
   output logic [15:0]                    err_data,
   output logic [15:0]                    last_len,
   output logic                           pack_done
);

   localparam int unsigned FLIT_SIZE = DATA_SIZE + ADDR_SIZE + 1;
   localparam int unsigned DW        = (READ_DELAY > 0) ? $clog2(READ_DELAY + 1) : 1;

   typedef enum logic [1:0] {StIdle, StBody, StDrop} state_e;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (&v) ? v : v + 16'd1;
   endfunction

   state_e          r_state, w_state_nxt;
   logic [15:0]     r_len, w_len_nxt;
   logic            r_addr_flag, w_addr_flag_nxt;
   logic [31:0]     r_recv_packs, w_recv_packs_nxt;
   logic [31:0]     r_recv_flits, w_recv_flits_nxt;
   logic [15:0]     r_err_addr, w_err_addr_nxt;
   logic [15:0]     r_err_len, w_err_len_nxt;
   logic [15:0]     r_last_len, w_last_len_nxt;
   logic            r_done, w_done_nxt;
   logic            r_ready, w_ready_nxt;
   logic [DW-1:0]   r_dly, w_dly_nxt;

   logic                 w_xfer;
   logic                 w_tail;
   logic [ADDR_SIZE-1:0] w_addr;
   logic                 w_addr_bad;
   logic [15:0]          w_len_inc;

   assign w_xfer     = wr_ready_in & r_ready;
   assign w_tail     = data_i[FLIT_SIZE-1];
   assign w_addr     = data_i[DATA_SIZE +: ADDR_SIZE];
   assign w_addr_bad = (w_addr != ADDR_SIZE'(ADDR));
   assign w_len_inc  = (r_state == StIdle) ? 16'd1 : r_len + 16'd1;

`ifdef PAYLOAD_CHECK_EN
   logic                 r_data_flag, w_data_flag_nxt;
   logic [15:0]          r_err_data, w_err_data_nxt;
   logic [15:0]          w_k;
   logic                 w_data_bad;

   // Flit index within the packet; the generator sends k mod 2^DATA_SIZE as payload.
   assign w_k        = (r_state == StIdle) ? 16'd0 : r_len;
   assign w_data_bad = (data_i[DATA_SIZE-1:0] != DATA_SIZE'(w_k));
   assign err_data   = r_err_data;
`else
   logic w_unused_data;
   assign w_unused_data = ^data_i[DATA_SIZE-1:0];
   assign err_data      = '0;
`endif

   always_comb begin
      w_state_nxt      = r_state;
      w_len_nxt        = r_len;
      w_addr_flag_nxt  = r_addr_flag;
      w_recv_packs_nxt = r_recv_packs;
      w_recv_flits_nxt = r_recv_flits;
      w_err_addr_nxt   = r_err_addr;
      w_err_len_nxt    = r_err_len;
      w_last_len_nxt   = r_last_len;
      w_done_nxt       = 1'b0;
`ifdef PAYLOAD_CHECK_EN
      w_data_flag_nxt  = r_data_flag;
      w_err_data_nxt   = r_err_data;
`endif
      if (w_xfer) begin
         w_recv_flits_nxt = sat_inc32(r_recv_flits);
         unique case (r_state)
            StIdle, StBody: begin
               w_len_nxt       = w_len_inc;
               w_addr_flag_nxt = w_addr_bad | ((r_state == StBody) & r_addr_flag);
`ifdef PAYLOAD_CHECK_EN
               w_data_flag_nxt = w_data_bad | ((r_state == StBody) & r_data_flag);
`endif
               if (w_tail) begin
                  w_state_nxt = StIdle;
                  if (w_addr_flag_nxt) begin
                     w_err_addr_nxt = sat_inc16(r_err_addr);
                  end
`ifdef PAYLOAD_CHECK_EN
                  else if (w_data_flag_nxt) begin
                     w_err_data_nxt = sat_inc16(r_err_data);
                  end
`endif
                  else begin
                     w_recv_packs_nxt = sat_inc32(r_recv_packs);
                     w_last_len_nxt   = w_len_inc;
                     w_done_nxt       = 1'b1;
                  end
               end else if (w_len_inc == 16'(MAX_PACK_LEN)) begin
                  // Overlength wins over any address/data fault of the same packet.
                  w_err_len_nxt = sat_inc16(r_err_len);
                  w_state_nxt   = StDrop;
               end else begin
                  w_state_nxt = StBody;
               end
            end
            StDrop: begin
               if (w_tail) w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
         endcase
      end
   end

   always_comb begin
      w_ready_nxt = r_ready;
      w_dly_nxt   = r_dly;
      if (w_xfer && (READ_DELAY != 0)) begin
         w_ready_nxt = 1'b0;
         w_dly_nxt   = DW'(READ_DELAY);
      end else if (r_dly != '0) begin
         w_dly_nxt   = r_dly - DW'(1);
         w_ready_nxt = (r_dly == DW'(1));
      end else begin
         w_ready_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (a_rst) begin
         r_state      <= StIdle;
         r_len        <= '0;
         r_addr_flag  <= 1'b0;
         r_recv_packs <= '0;
         r_recv_flits <= '0;
         r_err_addr   <= '0;
         r_err_len    <= '0;
         r_last_len   <= '0;
         r_done       <= 1'b0;
         r_ready      <= 1'b0;
         r_dly        <= '0;
`ifdef PAYLOAD_CHECK_EN
         r_data_flag  <= 1'b0;
         r_err_data   <= '0;
`endif
      end else begin
         r_state      <= w_state_nxt;
         r_len        <= w_len_nxt;
         r_addr_flag  <= w_addr_flag_nxt;
         r_recv_packs <= w_recv_packs_nxt;
         r_recv_flits <= w_recv_flits_nxt;
         r_err_addr   <= w_err_addr_nxt;
         r_err_len    <= w_err_len_nxt;
         r_last_len   <= w_last_len_nxt;
         r_done       <= w_done_nxt;
         r_ready      <= w_ready_nxt;
         r_dly        <= w_dly_nxt;
`ifdef PAYLOAD_CHECK_EN
         r_data_flag  <= w_data_flag_nxt;
         r_err_data   <= w_err_data_nxt;
`endif
      end
   end

   assign r_ready_out = r_ready;
   assign recv_packs  = r_recv_packs;
   assign recv_flits  = r_recv_flits;
   assign err_addr    = r_err_addr;
   assign err_len     = r_err_len;
   assign last_len    = r_last_len;
   assign pack_done   = r_done;

endmodule

// File: tb/tb_packet_sink.sv
// Bench for packet_sink: packet-level queue model checked every cycle, plus directed literals.
// A second instance with READ_DELAY=2 exercises flow control.
module tb_packet_sink;

   localparam int unsigned DS  = 8;
   localparam int unsigned AS  = 4;
   localparam int unsigned FS  = DS + AS + 1;
   localparam int unsigned MY  = 3;
   localparam int unsigned MAX = 4;

   logic          clk = 1'b0;
   logic          a_rst;
   logic [FS-1:0] din, din1;
   logic          wr, wr1;

   logic          rdy, rdy1;
   logic [31:0]   packs, flits, packs1, flits1;
   logic [15:0]   e_addr, e_len, e_data, l_len;
   logic [15:0]   e_addr1, e_len1, e_data1, l_len1;
   logic          done, done1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   packet_sink #(.DATA_SIZE(DS), .ADDR_SIZE(AS), .ADDR(MY), .MAX_PACK_LEN(MAX),
                 .READ_DELAY(0)) u_dut (
      .clk(clk), .a_rst(a_rst), .data_i(din), .wr_ready_in(wr), .r_ready_out(rdy),
      .recv_packs(packs), .recv_flits(flits), .err_addr(e_addr), .err_len(e_len),
      .err_data(e_data), .last_len(l_len), .pack_done(done)
   );

   packet_sink #(.DATA_SIZE(DS), .ADDR_SIZE(AS), .ADDR(MY), .MAX_PACK_LEN(MAX),
                 .READ_DELAY(2)) u_dut_dly (
      .clk(clk), .a_rst(a_rst), .data_i(din1), .wr_ready_in(wr1), .r_ready_out(rdy1),
      .recv_packs(packs1), .recv_flits(flits1), .err_addr(e_addr1), .err_len(e_len1),
      .err_data(e_data1), .last_len(l_len1), .pack_done(done1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Packet-level model: collect the flits of the current packet, judge it at the tail.
   logic [FS-1:0] m_q[$];
   bit            m_valid = 0;
   bit            m_ready, m_drop, m_done;
   int unsigned   m_packs, m_flits, m_eaddr, m_elen, m_edata, m_last;

   always @(posedge clk) begin
      bit bad_a, bad_d;
      m_valid = 1;
      if (a_rst) begin
         m_q.delete();
         m_ready = 0; m_drop = 0; m_done = 0;
         m_packs = 0; m_flits = 0; m_eaddr = 0; m_elen = 0; m_edata = 0; m_last = 0;
      end else begin
         m_done = 0;
         if (wr && m_ready) begin
            m_flits++;
            if (m_drop) begin
               if (din[FS-1]) m_drop = 0;
            end else begin
               m_q.push_back(din);
               if (din[FS-1]) begin
                  bad_a = 0; bad_d = 0;
                  foreach (m_q[k]) begin
                     if (m_q[k][DS +: AS] != MY) bad_a = 1;
                     if (m_q[k][DS-1:0] != (k % 256)) bad_d = 1;
                  end
`ifndef PAYLOAD_CHECK_EN
                  bad_d = 0;
`endif
                  if (bad_a) m_eaddr++;
                  else if (bad_d) m_edata++;
                  else begin
                     m_packs++;
                     m_last = m_q.size();
                     m_done = 1;
                  end
                  m_q.delete();
               end else if (m_q.size() == MAX) begin
                  m_elen++;
                  m_drop = 1;
                  m_q.delete();
               end
            end
         end
         m_ready = 1;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("m_ready", {31'd0, rdy}, {31'd0, m_ready});
         check("m_recv_packs", packs, m_packs);
         check("m_recv_flits", flits, m_flits);
         check("m_err_addr", {16'd0, e_addr}, m_eaddr);
         check("m_err_len", {16'd0, e_len}, m_elen);
         check("m_err_data", {16'd0, e_data}, m_edata);
         check("m_last_len", {16'd0, l_len}, m_last);
         check("m_pack_done", {31'd0, done}, {31'd0, m_done});
      end
   end

   task automatic flit(input bit t, input int unsigned a, input int unsigned d);
      wr  = 1'b1;
      din = {t, AS'(a), DS'(d)};
      @(posedge clk); #1;
      wr  = 1'b0;
   endtask

   task automatic idle(input int n);
      wr = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      a_rst = 1'b1; wr = 1'b0; wr1 = 1'b0; din = '0; din1 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", {31'd0, rdy}, 32'd0);
      check("rst_packs", packs, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      a_rst = 1'b0;
      @(posedge clk); #1;
      check("ready_after_rst", {31'd0, rdy}, 32'd1);

      // READ_DELAY=2 instance, wr held high with good single-flit packets
      wr1  = 1'b1;
      din1 = {1'b1, AS'(MY), DS'(0)};
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         check("dly_ready_pattern", {31'd0, rdy1}, (i % 3 == 0) ? 32'd1 : 32'd0);
         @(posedge clk); #1;
      end
      wr1 = 1'b0;
      check("dly_transfers", flits1, 32'd3);
      check("dly_packs", packs1, 32'd3);

      // 4-flit good packet (exactly MAX long)
      flit(0, MY, 0); flit(0, MY, 1); flit(0, MY, 2);
      check("t1_no_early_done", {31'd0, done}, 32'd0);
      flit(1, MY, 3);
      check("t1_done", {31'd0, done}, 32'd1);
      check("t1_packs", packs, 32'd1);
      check("t1_flits", flits, 32'd4);
      check("t1_last_len", {16'd0, l_len}, 32'd4);
      idle(1);
      check("t1_done_pulse", {31'd0, done}, 32'd0);

      // back-to-back single-flit packets
      flit(1, MY, 0);
      check("t2_done_a", {31'd0, done}, 32'd1);
      flit(1, MY, 0);
      check("t2_done_b", {31'd0, done}, 32'd1);
      check("t2_packs", packs, 32'd3);
      check("t2_last_len", {16'd0, l_len}, 32'd1);
      idle(1);

      // mis-addressed packet
      flit(0, 5, 0); flit(0, 5, 1); flit(1, 5, 2);
      check("t3_err_addr", {16'd0, e_addr}, 32'd1);
      check("t3_packs", packs, 32'd3);
      check("t3_flits", flits, 32'd9);
      check("t3_no_done", {31'd0, done}, 32'd0);
      idle(1);

      // overlength packet, then a good 2-flit packet
      flit(0, MY, 0); flit(0, MY, 1); flit(0, MY, 2); flit(0, MY, 3);
      check("t4_err_len", {16'd0, e_len}, 32'd1);
      flit(0, MY, 4); flit(1, MY, 5);
      check("t4_flits", flits, 32'd15);
      check("t4_packs", packs, 32'd3);
      flit(0, MY, 0); flit(1, MY, 1);
      check("t4_good_after", packs, 32'd4);
      check("t4_last_len", {16'd0, l_len}, 32'd2);
      idle(1);

      // overlength and mis-addressed: only err_len counts
      for (int i = 0; i < 5; i++) flit(i == 4, 7, i);
      check("t5_err_len", {16'd0, e_len}, 32'd2);
      check("t5_err_addr", {16'd0, e_addr}, 32'd1);
      idle(1);

      // payload sequence 0,1,7
      flit(0, MY, 0); flit(0, MY, 1); flit(1, MY, 7);
`ifdef PAYLOAD_CHECK_EN
      check("t6_err_data", {16'd0, e_data}, 32'd1);
      check("t6_packs", packs, 32'd4);
`else
      check("t6_err_data", {16'd0, e_data}, 32'd0);
      check("t6_packs", packs, 32'd5);
      check("t6_last_len", {16'd0, l_len}, 32'd3);
`endif
      idle(1);

      // reset mid-packet
      flit(0, MY, 0); flit(0, MY, 1);
      a_rst = 1'b1;
      @(posedge clk); #1;
      check("r_packs", packs, 32'd0);
      check("r_flits", flits, 32'd0);
      check("r_err_len", {16'd0, e_len}, 32'd0);
      check("r_err_addr", {16'd0, e_addr}, 32'd0);
      check("r_last_len", {16'd0, l_len}, 32'd0);
      check("r_ready", {31'd0, rdy}, 32'd0);
      a_rst = 1'b0;
      idle(1);
      flit(1, MY, 0);
      check("r_new_packs", packs, 32'd1);
      check("r_new_flits", flits, 32'd1);
      check("r_new_done", {31'd0, done}, 32'd1);
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
